stream_demux: RTL and testbench
===============================

STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width of every payload port.
REQ-002 The block SHALL have parameter CNTW, default 16, giving the width of each delivered-beat counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 choice  input  1  destination of the current input beat: 0 = out0, 1 = out1.
REQ-006 in_valid  input  1  the input beat is present.
REQ-007 in_data  input  WIDTH  input payload.
REQ-008 in_ready  output  1  the block can accept a beat to the destination given by choice.
REQ-009 out0_valid / out1_valid  output  1  the output port holds a beat.
REQ-010 out0_data / out1_data  output  WIDTH  head payload of the port.
REQ-011 out0_ready / out1_ready  input  1  the downstream sink takes the head beat.
REQ-012 cnt0 / cnt1  output  CNTW  beats delivered on out0 / out1.

Function
REQ-013 An input handshake SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-014 An output handshake SHALL occur on a rising edge where outN_valid=1 and outN_ready=1.
REQ-015 Each output port SHALL own an independent 2-entry buffer with states EMPTY, ONE and TWO.
REQ-016 in_ready SHALL equal "buffer selected by choice is not TWO".
- in_ready is combinational from choice and registered state only.
- in_ready SHALL NOT depend on in_valid or on any outN_ready.
REQ-017 An accepted beat SHALL enter only the buffer selected by choice at that edge.
REQ-018 The other buffer SHALL be unaffected by the accepted beat.
REQ-019 Latency: a beat accepted into an EMPTY buffer at edge k SHALL appear on outN_valid/outN_data in the cycle after edge k.
- Latency is 1 cycle.
- There is no combinational path from in_data to any output.
REQ-020 Buffer state transitions:
- EMPTY + push -> ONE.
- ONE + push without pop -> TWO.
- ONE + pop without push -> EMPTY.
- ONE + push + pop -> ONE, with the new beat at the head.
- TWO + pop -> ONE.
- TWO cannot receive a push, per REQ-016.
REQ-021 Each buffer SHALL deliver beats in acceptance order.
REQ-022 outN_data SHALL hold stable while outN_valid=1 and outN_ready=0.
REQ-023 outN_valid SHALL NOT fall without an output handshake.
REQ-024 When one port is stalled and choice selects the other, the block SHALL accept input beats for the other port at full rate.
REQ-025 Sustained traffic to one port with outN_ready held 1 SHALL achieve 1 beat per cycle.
REQ-026 choice changing while in_valid=1 and in_ready=0 SHALL be legal; in_ready SHALL re-evaluate for the new choice in the same cycle.
REQ-027 cntN SHALL increment by 1 on each output handshake on port N.
REQ-028 cntN SHALL wrap from all-ones to 0 with no flag.
REQ-029 Simultaneous handshakes on out0 and out1 SHALL increment both counters in the same edge.

Reset
REQ-030 While rst=1, independent of clk:
- both buffers SHALL be EMPTY;
- out0_valid and out1_valid SHALL be 0;
- out0_data and out1_data SHALL be 0;
- cnt0 and cnt1 SHALL be 0.
REQ-031 Beats held in either buffer when rst asserts mid-operation SHALL be discarded and never delivered.
REQ-032 The first rising edge after rst deasserts SHALL be able to accept a beat.
- in_ready SHALL be 1 during reset deassertion.

Structure
REQ-033 Buffer-state encodings and WIDTH/CNTW defaults SHALL live in the shared project header of defines.
- Encodings: EMPTY=2'b00, ONE=2'b01, TWO=2'b10.
REQ-034 The 2-entry buffer SHALL be one sub-module, skid_buf2 (clk, rst, push, push_data, full, pop, valid, head_data), instantiated twice.
REQ-035 Counters and in_ready steering SHALL reside in stream_demux.

Verification
REQ-036 Reset: assert rst mid-cycle with both buffers TWO -> out0_valid=0, out1_valid=0 and cnt0=0, cnt1=0 immediately; in_ready=1 after release.
REQ-037 Alternation: send 0x11 (choice=0), 0x22 (choice=1), 0x33 (choice=0) with both readies=1 -> out0 delivers 0x11 then 0x33; out1 delivers 0x22; each beat appears one cycle after acceptance; cnt0=2, cnt1=1.
REQ-038 Backpressure: out0_ready=0, push 0xA, 0xB, 0xC to port 0 -> in_ready drops after 0xB; 0xC is held; out0_data=0xA stays stable; releasing out0_ready delivers 0xA, 0xB, 0xC in order.
REQ-039 Isolation: out0 full and stalled, stream 4 beats to port 1 with out1_ready=1 -> all 4 are accepted on consecutive edges; out0 is unchanged.
REQ-040 Wrap: preload 0xFFFF deliveries on out1 (CNTW=16), then one more -> cnt1=0x0000; cnt0 is unaffected.
REQ-041 Simultaneous: port 0 in state ONE, push to port 0 and pop out0 on the same edge -> state stays ONE; head = new beat; cnt0 increments by 1.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared definitions for the stream demultiplexer: default widths and the
// state encoding of the per-port two-entry buffer.
package stream_demux_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNTW  = 16;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_TWO   = 2'b10
    } buf_state_t;

endpackage

// File: rtl/stream_demux_if.sv
// Handshake bundle of the stream demultiplexer: one input stream with a
// destination select and two output streams.
interface stream_demux_if
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             choice;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;

    logic             out0_valid;
    logic [WIDTH-1:0] out0_data;
    logic             out0_ready;

    logic             out1_valid;
    logic [WIDTH-1:0] out1_data;
    logic             out1_ready;

    // Source/sink side: drives the input stream and the output readies.
    modport master (
        output choice, in_valid, in_data, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data
    );

    // Demultiplexer side.
    modport slave (
        input  choice, in_valid, in_data, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data
    );

endinterface

// File: rtl/stream_demux_skid_buf2.sv
// Two-entry in-order buffer with a registered head. A push into an empty
// buffer is visible at the head one cycle later; push and pop may coincide.
module skid_buf2
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head_data
);

    buf_state_t       state, state_nxt;
    logic [WIDTH-1:0] head_q, head_nxt;
    logic [WIDTH-1:0] tail_q, tail_nxt;

    // Occupancy state register; reset discards anything held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BUF_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Head/tail storage; cleared on reset so outputs read zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_nxt;
            tail_q <= tail_nxt;
        end
    end

    // Next occupancy and data movement. A push while full is never issued by
    // the parent, so TWO ignores push.
    always_comb begin
        state_nxt = state;
        head_nxt  = head_q;
        tail_nxt  = tail_q;
        case (state)
            BUF_EMPTY: begin
                if (push) begin
                    state_nxt = BUF_ONE;
                    head_nxt  = push_data;
                end
            end
            BUF_ONE: begin
                if (push && pop) begin
                    head_nxt = push_data;
                end else if (push) begin
                    state_nxt = BUF_TWO;
                    tail_nxt  = push_data;
                end else if (pop) begin
                    state_nxt = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                if (pop) begin
                    state_nxt = BUF_ONE;
                    head_nxt  = tail_q;
                end
            end
            default: begin
                state_nxt = BUF_EMPTY;
            end
        endcase
    end

    assign full      = (state == BUF_TWO);
    assign valid     = (state != BUF_EMPTY);
    assign head_data = head_q;

endmodule

// File: rtl/stream_demux.sv
// One-to-two stream demultiplexer. Each destination owns a two-entry buffer,
// so a stalled port never blocks traffic to the other. Per-port counters
// track delivered beats and wrap silently.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic            clk,
    input  logic            rst,
    stream_demux_if.slave   bus,
    output logic [CNTW-1:0] cnt0,
    output logic [CNTW-1:0] cnt1
);

    logic full0, full1;
    logic accept;
    logic push0, push1;
    logic pop0, pop1;

    // Ready depends only on the selected buffer's occupancy, never on
    // in_valid or the downstream readies.
    assign bus.in_ready = bus.choice ? !full1 : !full0;
    assign accept       = bus.in_valid && bus.in_ready;
    assign push0        = accept && !bus.choice;
    assign push1        = accept && bus.choice;
    assign pop0         = bus.out0_valid && bus.out0_ready;
    assign pop1         = bus.out1_valid && bus.out1_ready;

    skid_buf2 #(.WIDTH(WIDTH)) u_buf0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push0),
        .push_data (bus.in_data),
        .full      (full0),
        .pop       (pop0),
        .valid     (bus.out0_valid),
        .head_data (bus.out0_data)
    );

    skid_buf2 #(.WIDTH(WIDTH)) u_buf1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push1),
        .push_data (bus.in_data),
        .full      (full1),
        .pop       (pop1),
        .valid     (bus.out1_valid),
        .head_data (bus.out1_data)
    );

    // Delivered-beat counters, one per port, wrapping without a flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (pop0) cnt0 <= cnt0 + CNTW'(1);
            if (pop1) cnt1 <= cnt1 + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: directed scenarios plus randomized traffic, all
// checked against a queue-based model of two independent 2-deep FIFOs.
module tb_stream_demux;

    localparam int WIDTH = 32;
    localparam int CNTW  = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [CNTW-1:0] cnt0, cnt1;

    stream_demux_if #(.WIDTH(WIDTH)) bus ();

    stream_demux #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .cnt0 (cnt0),
        .cnt1 (cnt1)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: each port is a FIFO of capacity 2 plus a delivery count.
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    logic [CNTW-1:0]  m_cnt0 = '0;
    logic [CNTW-1:0]  m_cnt1 = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic ch, input logic [WIDTH-1:0] d,
                         input logic r0, input logic r1);
        bus.in_valid   = v;
        bus.choice     = ch;
        bus.in_data    = d;
        bus.out0_ready = r0;
        bus.out1_ready = r1;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the
    // model by the handshakes the model predicts. Returns whether the input
    // beat was accepted.
    task automatic step(output logic acc);
        logic             exp_rdy, p0, p1, ch;
        logic [WIDTH-1:0] d;
        @(negedge clk);
        exp_rdy = bus.choice ? (q1.size() < 2) : (q0.size() < 2);
        chk("in_ready", bus.in_ready, exp_rdy);
        chk("out0_valid", bus.out0_valid, q0.size() > 0);
        chk("out1_valid", bus.out1_valid, q1.size() > 0);
        if (q0.size() > 0) chk("out0_data", bus.out0_data, q0[0]);
        if (q1.size() > 0) chk("out1_data", bus.out1_data, q1[0]);
        chk("cnt0", cnt0, m_cnt0);
        chk("cnt1", cnt1, m_cnt1);
        acc = bus.in_valid && exp_rdy;
        p0  = (q0.size() > 0) && bus.out0_ready;
        p1  = (q1.size() > 0) && bus.out1_ready;
        ch  = bus.choice;
        d   = bus.in_data;
        @(posedge clk);
        if (p0) begin void'(q0.pop_front()); m_cnt0++; end
        if (p1) begin void'(q1.pop_front()); m_cnt1++; end
        if (acc) begin
            if (ch) q1.push_back(d);
            else    q0.push_back(d);
        end
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle; returns shortly after release,
    // before the next rising edge.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_out0_valid", bus.out0_valid, 1'b0);
        chk("rst_out1_valid", bus.out1_valid, 1'b0);
        chk("rst_out0_data", bus.out0_data, '0);
        chk("rst_out1_data", bus.out1_data, '0);
        chk("rst_cnt0", cnt0, '0);
        chk("rst_cnt1", cnt1, '0);
        q0.delete();
        q1.delete();
        m_cnt0 = '0;
        m_cnt1 = '0;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rel_ready_c0", bus.in_ready, 1'b1);
        bus.choice = 1'b1;
        #0;
        chk("rel_ready_c1", bus.in_ready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        logic        acc;
        logic [CNTW-1:0] c0_save;
        bit          got;

        rst = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        #1;
        chk("init_out0_valid", bus.out0_valid, 1'b0);
        chk("init_out1_valid", bus.out1_valid, 1'b0);
        chk("init_cnt0", cnt0, '0);
        chk("init_cnt1", cnt1, '0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("init_ready", bus.in_ready, 1'b1);

        // Alternating destinations with both sinks ready.
        drive(1'b1, 1'b0, 32'h11, 1'b1, 1'b1); step(acc);
        chk("alt_lat0_valid", bus.out0_valid, 1'b1);
        chk("alt_lat0_data", bus.out0_data, 32'h11);
        drive(1'b1, 1'b1, 32'h22, 1'b1, 1'b1); step(acc);
        chk("alt_lat1_data", bus.out1_data, 32'h22);
        drive(1'b1, 1'b0, 32'h33, 1'b1, 1'b1); step(acc);
        chk("alt_lat0b_data", bus.out0_data, 32'h33);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        step(acc); step(acc);
        chk("alt_cnt0", cnt0, 16'd2);
        chk("alt_cnt1", cnt1, 16'd1);

        // Backpressure on port 0.
        drive(1'b1, 1'b0, 32'hA, 1'b0, 1'b1); step(acc);
        drive(1'b1, 1'b0, 32'hB, 1'b0, 1'b1); step(acc);
        chk("bp_ready_drop", bus.in_ready, 1'b0);
        drive(1'b1, 1'b0, 32'hC, 1'b0, 1'b1); step(acc);
        chk("bp_c_held", acc, 1'b0);
        step(acc);
        chk("bp_head_stable", bus.out0_data, 32'hA);
        drive(1'b1, 1'b0, 32'hC, 1'b1, 1'b1);
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            step(acc);
            if (acc) got = 1;
        end
        chk("bp_c_accept", got, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(acc);
        chk("bp_cnt0", cnt0, 16'd5);

        // Isolation: port 0 full and stalled, port 1 streams at full rate.
        drive(1'b1, 1'b0, 32'hD0, 1'b0, 1'b1); step(acc);
        drive(1'b1, 1'b0, 32'hD1, 1'b0, 1'b1); step(acc);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 32'hE0 + i, 1'b0, 1'b1);
            step(acc);
            chk("iso_accept", acc, 1'b1);
        end
        chk("iso_out0_head", bus.out0_data, 32'hD0);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(acc);

        // Simultaneous push and pop on port 0 holding one beat.
        drive(1'b1, 1'b0, 32'h44, 1'b0, 1'b1); step(acc);
        c0_save = cnt0;
        drive(1'b1, 1'b0, 32'h55, 1'b1, 1'b1); step(acc);
        chk("sim_cnt0", cnt0, c0_save + 16'd1);
        chk("sim_head", bus.out0_data, 32'h55);
        chk("sim_valid", bus.out0_valid, 1'b1);
        chk("sim_ready", bus.in_ready, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        step(acc); step(acc);

        // Fill both buffers, then reset mid-operation.
        drive(1'b1, 1'b0, 32'hF0, 1'b0, 1'b0); step(acc);
        drive(1'b1, 1'b0, 32'hF1, 1'b0, 1'b0); step(acc);
        drive(1'b1, 1'b1, 32'hF2, 1'b0, 1'b0); step(acc);
        drive(1'b1, 1'b1, 32'hF3, 1'b0, 1'b0); step(acc);
        chk("pre_rst_full0", bus.in_ready, 1'b0);
        async_reset();
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(acc);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
            step(acc);
        end
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(acc);

        // Counter wrap on port 1.
        async_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h700 + i, 1'b1, 1'b1);
            step(acc);
        end
        for (int i = 0; i < 65532; i++) begin
            drive(1'b1, 1'b1, i, 1'b1, 1'b1);
            step(acc);
        end
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        step(acc); step(acc);
        chk("wrap_pre_cnt1", cnt1, 16'hFFFC);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'h900 + i, 1'b1, 1'b1);
            step(acc);
        end
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        step(acc); step(acc);
        chk("wrap_max_cnt1", cnt1, 16'hFFFF);
        drive(1'b1, 1'b1, 32'hABC, 1'b1, 1'b1); step(acc);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        step(acc); step(acc);
        chk("wrap_cnt1", cnt1, 16'h0000);
        chk("wrap_cnt0", cnt0, 16'd3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
